// File: rtl/i2s_tx_mc_fifo.sv
// i2s_tx_mc_fifo: multi-lane I2S / left-justified transmitter fed by a
// sample-frame FIFO. A free-running frame counter on AMCLK_i generates
// BCK and WS; once per frame the next FIFO entry is moved into a holding
// register and serialised MSB first on every lane in parallel.
//
// Optional build macro I2S_TX_UNDERFLOW_REPEAT_EN: when defined, a frame
// that finds the FIFO empty re-sends the previous frame. When it is not
// defined, such a frame sends zeros.
//
// Handshake: a frame is accepted on any AMCLK_i edge where APDATA_VALID_i
// and APDATA_READY_o are both high. READY only means "FIFO not full".
// VALID presented while READY is low is discarded, not held pending.
module i2s_tx_mc_fifo #(
    parameter int I2S_DATA_BITS      = 24,
    parameter int NUM_LANES          = 2,
    parameter int I2S_BCKS_PER_FRAME = 64,
    parameter int MCLK_FRAME_DIVIDER = 512,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                                 AMCLK_i,
    input  logic                                 reset_n,
    input  logic [NUM_LANES*2*I2S_DATA_BITS-1:0] APSDATA_i,
    input  logic                                 APDATA_VALID_i,
    output logic                                 APDATA_READY_o,
    input  logic                                 FMT_LJ_i,
    output logic [$clog2(FIFO_DEPTH):0]          FIFO_LEVEL_o,
    output logic                                 UNDERFLOW_o,
    output logic                                 I2S_BCK,
    output logic                                 I2S_WS,
    output logic [NUM_LANES-1:0]                 I2S_DATA
);

    localparam int FW = NUM_LANES * 2 * I2S_DATA_BITS;  // frame width
    localparam int CW = $clog2(MCLK_FRAME_DIVIDER);     // frame counter width
    localparam int BW = $clog2(I2S_BCKS_PER_FRAME);     // bits of BCK index in frame
    localparam int SB = CW - 1 - BW;                    // ctr bit that is BCK
    localparam int PW = BW - 1;                         // bits of position in slot
    localparam int AW = $clog2(FIFO_DEPTH);             // FIFO pointer width
    localparam int LW = AW + 1;                         // FIFO level width

    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [PW:0]   BITS_P     = (PW + 1)'(I2S_DATA_BITS);

    logic [CW-1:0]    ctr;
    logic [FW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [FW-1:0]    hold_q;
    logic             fmt_q;
    logic             underflow_q;
    logic [NUM_LANES-1:0] data_q;
    logic [NUM_LANES-1:0] data_nxt;

    logic             frame_end;
    logic             bck_phase_zero;
    logic             ready;
    logic             push;
    logic             pop;
    logic             slot_right;
    logic [PW-1:0]    pos;

    // Frame timing is taken directly from the counter bits
    assign frame_end      = (ctr == '1);
    assign bck_phase_zero = (ctr[SB:0] == '0);
    assign slot_right     = ctr[CW-1];
    assign pos            = ctr[CW-2:SB+1];

    assign I2S_WS  = ctr[CW-1];
    assign I2S_BCK = ctr[SB];

    // READY is gated by reset_n so nothing is accepted while reset is held
    assign ready = reset_n && (level != FULL_LEVEL);
    assign push  = APDATA_VALID_i && ready;
    // The pop decision uses the level before this edge. A push in the same
    // cycle at level 0 is stored but cannot feed this frame.
    assign pop   = frame_end && (level != '0);

    assign APDATA_READY_o = ready;
    assign FIFO_LEVEL_o   = level;
    assign UNDERFLOW_o    = underflow_q;
    assign I2S_DATA       = data_q;

    // Free-running frame counter; wraps naturally because the divider is a power of 2
    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + CW'(1);
        end
    end

    // FIFO storage; entries past the read pointer are invalid, so no reset is needed
    always_ff @(posedge AMCLK_i) begin
        if (push) begin
            mem[wr_ptr] <= APSDATA_i;
        end
    end

    // FIFO pointers and level; push and pop in the same cycle leave the level unchanged
    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Load the frame to transmit at the last cycle of each frame; latch the format alongside
    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            hold_q <= '0;
            fmt_q  <= 1'b0;
        end else if (frame_end) begin
            fmt_q <= FMT_LJ_i;
            if (pop) begin
                hold_q <= mem[rd_ptr];
            end else begin
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
                hold_q <= hold_q;
`else
                hold_q <= '0;
`endif
            end
        end
    end

    // Sticky underflow: a frame boundary with nothing queued
    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            underflow_q <= 1'b0;
        end else if (frame_end && (level == '0)) begin
            underflow_q <= 1'b1;
        end
    end

    // Select the serial bit for the current slot position on every lane
    always_comb begin
        logic [I2S_DATA_BITS-1:0] sample;
        logic [I2S_DATA_BITS-1:0] shifted;
        data_nxt = '0;
        sample   = '0;
        shifted  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (slot_right) begin
                sample = hold_q[2*l*I2S_DATA_BITS +: I2S_DATA_BITS];
            end else begin
                sample = hold_q[(2*l+1)*I2S_DATA_BITS +: I2S_DATA_BITS];
            end
            if (fmt_q) begin
                // Left-justified: MSB sits at position 0
                shifted = sample << pos;
                if ({1'b0, pos} < BITS_P) begin
                    data_nxt[l] = shifted[I2S_DATA_BITS-1];
                end
            end else begin
                // I2S: one idle BCK, then MSB at position 1
                shifted = sample << (pos - PW'(1));
                if ((pos != '0) && ({1'b0, pos} <= BITS_P)) begin
                    data_nxt[l] = shifted[I2S_DATA_BITS-1];
                end
            end
        end
    end

    // Serial data changes one AMCLK after BCK falls, so it is stable across BCK rise
    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (bck_phase_zero) begin
            data_q <= data_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx_mc_fifo.sv
// tb_i2s_tx_mc_fifo: self-checking bench for i2s_tx_mc_fifo. The reference
// model keeps the FIFO as a queue of frames, tracks the frame phase with a
// cycle count, and derives every serial bit from the slot and position
// within the frame.
module tb_i2s_tx_mc_fifo;

    localparam int BITS    = 24;
    localparam int LANES   = 2;
    localparam int BCKS    = 64;
    localparam int DIV     = 512;
    localparam int DEPTH   = 4;
    localparam int FW      = LANES * 2 * BITS;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int BCK_DIV = DIV / BCKS;
    localparam int SLOT    = BCKS / 2;

    localparam logic [FW-1:0] SPEC_FRAME =
        {24'h123456, 24'hFEDCBA, 24'hA5A5A5, 24'h5A5A5A};

    logic             AMCLK_i = 1'b0;
    logic             reset_n = 1'b0;
    logic [FW-1:0]    APSDATA_i = '0;
    logic             APDATA_VALID_i = 1'b0;
    logic             APDATA_READY_o;
    logic             FMT_LJ_i = 1'b0;
    logic [LW-1:0]    FIFO_LEVEL_o;
    logic             UNDERFLOW_o;
    logic             I2S_BCK;
    logic             I2S_WS;
    logic [LANES-1:0] I2S_DATA;

    i2s_tx_mc_fifo #(
        .I2S_DATA_BITS     (BITS),
        .NUM_LANES         (LANES),
        .I2S_BCKS_PER_FRAME(BCKS),
        .MCLK_FRAME_DIVIDER(DIV),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .AMCLK_i       (AMCLK_i),
        .reset_n       (reset_n),
        .APSDATA_i     (APSDATA_i),
        .APDATA_VALID_i(APDATA_VALID_i),
        .APDATA_READY_o(APDATA_READY_o),
        .FMT_LJ_i      (FMT_LJ_i),
        .FIFO_LEVEL_o  (FIFO_LEVEL_o),
        .UNDERFLOW_o   (UNDERFLOW_o),
        .I2S_BCK       (I2S_BCK),
        .I2S_WS        (I2S_WS),
        .I2S_DATA      (I2S_DATA)
    );

    // Clock
    always #5 AMCLK_i = ~AMCLK_i;

    // Scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [FW-1:0] exp_q[$];       // frames accepted but not yet transmitted
    logic [FW-1:0] m_cur = '0;     // frame being transmitted
    logic          m_fmt = 1'b0;   // format of the frame being transmitted
    logic          m_uf  = 1'b0;
    logic          m_rst_edge = 1'b0;
    int            m_cyc = 0;      // counter value after the most recent edge

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle-in-frame %0d, t=%0t)",
                     tag, got, exp, m_cyc, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [FW-1:0] fr, input logic lj,
                                     input int lane, input int bidx);
        int slot = bidx / SLOT;
        int p    = bidx % SLOT;
        logic [BITS-1:0] s;
        s = (slot == 0) ? fr[(2*lane+1)*BITS +: BITS] : fr[2*lane*BITS +: BITS];
        if (lj) return (p < BITS) ? s[BITS-1-p] : 1'b0;
        return (p >= 1 && p <= BITS) ? s[BITS-p] : 1'b0;
    endfunction

    // Advance the model across the coming clock edge using the current inputs
    task automatic model_edge();
        if (!reset_n) begin
            exp_q.delete();
            m_cur = '0;
            m_fmt = 1'b0;
            m_uf  = 1'b0;
            m_cyc = 0;
            m_rst_edge = 1'b1;
        end else begin
            bit room = (exp_q.size() < DEPTH);
            m_rst_edge = 1'b0;
            if (m_cyc == DIV - 1) begin
                m_fmt = FMT_LJ_i;
                if (exp_q.size() > 0) begin
                    m_cur = exp_q.pop_front();
                end else begin
                    m_uf = 1'b1;
`ifndef I2S_TX_UNDERFLOW_REPEAT_EN
                    m_cur = '0;
`endif
                end
            end
            if (APDATA_VALID_i && room) exp_q.push_back(APSDATA_i);
            m_cyc = (m_cyc + 1) % DIV;
        end
    endtask

    task automatic compare();
        logic [LANES-1:0] exp_d;
        int ph  = m_cyc % BCK_DIV;
        int pos = m_cyc / BCK_DIV;
        bit do_data = 1'b1;
        exp_d = '0;
        check("ready", 32'(APDATA_READY_o), 32'(reset_n && (exp_q.size() < DEPTH)));
        check("level", 32'(FIFO_LEVEL_o), 32'(exp_q.size()));
        check("underflow", 32'(UNDERFLOW_o), 32'(m_uf));
        check("ws", 32'(I2S_WS), 32'(m_cyc >= DIV / 2));
        check("bck", 32'(I2S_BCK), 32'(ph >= BCK_DIV / 2));
        if (ph != 0) begin
            for (int l = 0; l < LANES; l++) exp_d[l] = exp_bit(m_cur, m_fmt, l, pos);
        end else if (m_cyc != 0) begin
            for (int l = 0; l < LANES; l++) exp_d[l] = exp_bit(m_cur, m_fmt, l, pos - 1);
        end else if (!m_rst_edge) begin
            // last bit of the previous frame; its frame has already been replaced
            do_data = 1'b0;
        end
        if (do_data) check("i2s_data", 32'(I2S_DATA), 32'(exp_d));
    endtask

    // Driver tasks
    task automatic tick();
        model_edge();
        @(posedge AMCLK_i);
        #1;
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic goto_ctr(input int c);
        for (int i = 0; i < DIV && m_cyc != c; i++) tick();
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    task automatic push(input logic [FW-1:0] fr);
        APSDATA_i = fr;
        APDATA_VALID_i = 1'b1;
        tick();
        APDATA_VALID_i = 1'b0;
        APSDATA_i = rand_frame();
    endtask

    // Runs up to the pop cycle with random format toggles and optional random pushes
    task automatic frame_random(input bit pushes);
        for (int i = 0; i < DIV && m_cyc != DIV - 1; i++) begin
            if ($urandom_range(0, 31) == 0) FMT_LJ_i = ~FMT_LJ_i;
            APSDATA_i = rand_frame();
            APDATA_VALID_i = pushes && ($urandom_range(0, 99) == 0);
            tick();
        end
        APDATA_VALID_i = 1'b0;
    endtask

    initial begin
        // Reset
        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;
        run(5);

        // I2S frame with the reference data
        FMT_LJ_i = 1'b0;
        push(SPEC_FRAME);
        goto_ctr(DIV - 1);
        tick();
        run(100);
        // same data queued for a left-justified frame
        push(SPEC_FRAME);
        FMT_LJ_i = 1'b1;
        goto_ctr(DIV - 1);
        tick();

        // Format toggles mid-frame only take effect at the next frame
        push(rand_frame());
        frame_random(1'b0);
        tick();

        // Fill the FIFO, offer an extra frame while full, then let it drain
        while (exp_q.size() < DEPTH && m_cyc < DIV - 8) push(rand_frame());
        push(rand_frame());
        push(rand_frame());
        goto_ctr(DIV - 1);
        tick();
        for (int f = 0; f < DEPTH + 1; f++) begin
            frame_random(1'b0);
            tick();
        end

        // Refill after underflow; the flag must stay set
        push(rand_frame());
        goto_ctr(DIV - 1);
        tick();
        goto_ctr(DIV - 1);
        tick();

        // Level 1 with a push on the pop cycle, then level 0 with a push on the pop cycle
        run(50);
        push(rand_frame());
        goto_ctr(DIV - 1);
        push(rand_frame());
        goto_ctr(DIV - 1);
        tick();
        goto_ctr(DIV - 1);
        push(rand_frame());

        // Reset mid-frame with three frames queued
        run(20);
        while (exp_q.size() < 3) push(rand_frame());
        goto_ctr(200);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run(10);

        // Random traffic
        push(rand_frame());
        for (int f = 0; f < 6; f++) begin
            frame_random(1'b1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
